// File: rtl/e203_ifu_pfetch_q.sv
// e203_ifu_pfetch_q: multi-outstanding sequential instruction fetch with an in-order instruction queue
module e203_ifu_pfetch_q #(
  parameter int PC_W     = 32,
  parameter int INSTR_W  = 32,
  parameter int OUTS_MAX = 2,
  parameter int Q_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_rtvec,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_W-1:0]    ifu_req_pc,
  output logic               ifu_req_seq,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic               ifu_rsp_err,
  input  logic [INSTR_W-1:0] ifu_rsp_instr,
  output logic               ifu_o_valid,
  input  logic               ifu_o_ready,
  output logic [INSTR_W-1:0] ifu_o_ir,
  output logic [PC_W-1:0]    ifu_o_pc,
  output logic               ifu_o_buserr,
  input  logic               pipe_flush_req,
  input  logic [PC_W-1:0]    pipe_flush_pc,
  output logic               pipe_flush_ack,
  input  logic               ifu_halt_req,
  output logic               ifu_halt_ack
);
  localparam int CW = $clog2(Q_DEPTH + OUTS_MAX + 1);
  localparam int QA = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int PA = (OUTS_MAX > 1) ? $clog2(OUTS_MAX) : 1;
  logic               reset_req, first_req;
  logic [PC_W-1:0]    npc;
  logic [CW-1:0]      outs_cnt, drop_cnt, q_cnt, outs_nxt;
  logic [QA-1:0]      q_wp, q_rp;
  logic [PA-1:0]      p_wp, p_rp;
  logic [INSTR_W-1:0] q_ir [Q_DEPTH];
  logic [PC_W-1:0]    q_pc [Q_DEPTH];
  logic [Q_DEPTH-1:0] q_err;
  logic [PC_W-1:0]    p_pc [OUTS_MAX];
  logic               can_issue, req_hsk, rsp_hsk, push, pop;

  function automatic logic [QA-1:0] q_inc(input logic [QA-1:0] p);
    return (p == QA'(Q_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PA-1:0] p_inc(input logic [PA-1:0] p);
    return (p == PA'(OUTS_MAX - 1)) ? '0 : p + 1'b1;
  endfunction

  // outs_cnt + q_cnt bounds every possible future push, so the queue can never overflow
  assign can_issue = ~reset_req & (outs_cnt < CW'(OUTS_MAX)) & ((outs_cnt + q_cnt) < CW'(Q_DEPTH))
                   & ~pipe_flush_req & ~ifu_halt_req;
  assign req_hsk   = ifu_req_valid & ifu_req_ready;
  assign rsp_hsk   = ifu_rsp_valid & ifu_rsp_ready;
  assign push      = rsp_hsk & (drop_cnt == '0) & ~pipe_flush_req;
  assign pop       = ifu_o_valid & ifu_o_ready;
  assign outs_nxt  = outs_cnt + CW'(req_hsk) - CW'(rsp_hsk);

  assign ifu_req_valid  = can_issue;
  assign ifu_req_pc     = npc;
  assign ifu_req_seq    = ~first_req;
  assign ifu_rsp_ready  = rst_n;
  assign ifu_o_valid    = q_cnt != '0;
  assign ifu_o_ir       = q_ir[q_rp];
  assign ifu_o_pc       = q_pc[q_rp];
  assign ifu_o_buserr   = q_err[q_rp];
  assign pipe_flush_ack = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reset_req    <= 1'b1;
      first_req    <= 1'b1;
      npc          <= '0;
      outs_cnt     <= '0;
      drop_cnt     <= '0;
      q_cnt        <= '0;
      q_wp         <= '0;
      q_rp         <= '0;
      p_wp         <= '0;
      p_rp         <= '0;
      ifu_halt_ack <= 1'b0;
    end else begin
      reset_req    <= 1'b0;
      npc          <= reset_req ? pc_rtvec : pipe_flush_req ? pipe_flush_pc : req_hsk ? npc + PC_W'(4) : npc;
      first_req    <= reset_req | pipe_flush_req | (first_req & ~req_hsk);
      outs_cnt     <= outs_nxt;
      drop_cnt     <= pipe_flush_req ? outs_cnt - CW'(rsp_hsk)
                    : (rsp_hsk && drop_cnt != '0) ? drop_cnt - 1'b1 : drop_cnt;
      ifu_halt_ack <= ifu_halt_req & (outs_nxt == '0);
      p_wp         <= req_hsk ? p_inc(p_wp) : p_wp;
      p_rp         <= rsp_hsk ? p_inc(p_rp) : p_rp;
      q_wp         <= push ? q_inc(q_wp) : q_wp;
      q_rp         <= pipe_flush_req ? q_wp : pop ? q_inc(q_rp) : q_rp;
      q_cnt        <= pipe_flush_req ? '0 : q_cnt + CW'(push) - CW'(pop);
    end
  end

  // the PC FIFO advances on every response, dropped or not, to stay aligned with the bus order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Q_DEPTH; i++) begin
        q_ir[i] <= '0;
        q_pc[i] <= '0;
      end
      for (int i = 0; i < OUTS_MAX; i++) p_pc[i] <= '0;
      q_err <= '0;
    end else begin
      if (push) begin
        q_ir[q_wp]  <= ifu_rsp_instr;
        q_pc[q_wp]  <= p_pc[p_rp];
        q_err[q_wp] <= ifu_rsp_err;
      end
      if (req_hsk) p_pc[p_wp] <= npc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && q_cnt == CW'(Q_DEPTH)));
endmodule

// File: tb/tb_e203_ifu_pfetch_q.sv
// tb_e203_ifu_pfetch_q: directed scenario bench with a 1-cycle-latency fetch responder
module tb_e203_ifu_pfetch_q;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] pc_rtvec = 32'h8000_0000;
  logic        ifu_req_valid, ifu_req_ready, ifu_req_seq;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_o_valid, ifu_o_ready, ifu_o_buserr;
  logic [31:0] ifu_o_ir, ifu_o_pc;
  logic        pipe_flush_req, pipe_flush_ack, ifu_halt_req, ifu_halt_ack;
  logic [31:0] pipe_flush_pc;
  logic        rsp_en;
  logic [31:0] err_pc;
  logic [31:0] pend[$], rq_pc[$], o_pc_l[$], o_ir_l[$];
  logic        rq_seq[$], o_err_l[$];
  int          n_chk = 0, n_fail = 0;

  e203_ifu_pfetch_q dut (
    .clk(clk), .rst_n(rst_n), .pc_rtvec(pc_rtvec),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc), .ifu_req_seq(ifu_req_seq),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_err(ifu_rsp_err), .ifu_rsp_instr(ifu_rsp_instr),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_ir(ifu_o_ir), .ifu_o_pc(ifu_o_pc), .ifu_o_buserr(ifu_o_buserr),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc), .pipe_flush_ack(pipe_flush_ack),
    .ifu_halt_req(ifu_halt_req), .ifu_halt_ack(ifu_halt_ack)
  );

  always #5 clk = ~clk;

  // one clock: drive the response, log handshakes mid-cycle, then step past the next edge
  task automatic cycle();
    ifu_rsp_valid = rsp_en && pend.size() > 0;
    ifu_rsp_instr = ifu_rsp_valid ? ~pend[0] : 32'h0;
    ifu_rsp_err   = ifu_rsp_valid && pend[0] == err_pc;
    #1;
    if (ifu_req_valid && ifu_req_ready) begin
      rq_pc.push_back(ifu_req_pc);
      rq_seq.push_back(ifu_req_seq);
      pend.push_back(ifu_req_pc);
    end
    if (ifu_rsp_valid && ifu_rsp_ready) void'(pend.pop_front());
    if (ifu_o_valid && ifu_o_ready) begin
      o_pc_l.push_back(ifu_o_pc);
      o_ir_l.push_back(ifu_o_ir);
      o_err_l.push_back(ifu_o_buserr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifu_req_ready = 1'b1; ifu_o_ready = 1'b1; rsp_en = 1'b1;
    pipe_flush_req = 1'b0; pipe_flush_pc = 32'h0; ifu_halt_req = 1'b0;
    ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_instr = 32'h0; err_pc = 32'hFFFF_FFFF;
    pend.delete(); rq_pc.delete(); rq_seq.delete(); o_pc_l.delete(); o_ir_l.delete(); o_err_l.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_chk++; if (ifu_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %h expected 0", ifu_req_valid); end
    n_chk++; if (ifu_req_seq !== 1'b0) begin n_fail++; $display("FAIL rst_req_seq: got %h expected 0", ifu_req_seq); end
    n_chk++; if (ifu_o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_o_valid: got %h expected 0", ifu_o_valid); end
    n_chk++; if (ifu_halt_ack !== 1'b0) begin n_fail++; $display("FAIL rst_halt_ack: got %h expected 0", ifu_halt_ack); end
    n_chk++; if (ifu_o_ir !== 32'h0) begin n_fail++; $display("FAIL rst_o_ir: got %h expected 0", ifu_o_ir); end
    n_chk++; if (ifu_o_pc !== 32'h0) begin n_fail++; $display("FAIL rst_o_pc: got %h expected 0", ifu_o_pc); end
    n_chk++; if (ifu_o_buserr !== 1'b0) begin n_fail++; $display("FAIL rst_o_buserr: got %h expected 0", ifu_o_buserr); end
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    repeat (8) cycle();
    n_chk++; if (rq_pc.size() < 3 || o_pc_l.size() < 3) begin n_fail++; $display("FAIL seq_count: got req %0d out %0d expected >= 3", rq_pc.size(), o_pc_l.size()); end
    n_chk++; if (rq_pc[0] !== 32'h8000_0000) begin n_fail++; $display("FAIL seq_req0_pc: got %h expected 80000000", rq_pc[0]); end
    n_chk++; if (rq_pc[1] !== 32'h8000_0004) begin n_fail++; $display("FAIL seq_req1_pc: got %h expected 80000004", rq_pc[1]); end
    n_chk++; if (rq_pc[2] !== 32'h8000_0008) begin n_fail++; $display("FAIL seq_req2_pc: got %h expected 80000008", rq_pc[2]); end
    n_chk++; if (rq_seq[0] !== 1'b0) begin n_fail++; $display("FAIL seq_req0_seq: got %h expected 0", rq_seq[0]); end
    n_chk++; if (rq_seq[1] !== 1'b1) begin n_fail++; $display("FAIL seq_req1_seq: got %h expected 1", rq_seq[1]); end
    n_chk++; if (rq_seq[2] !== 1'b1) begin n_fail++; $display("FAIL seq_req2_seq: got %h expected 1", rq_seq[2]); end
    n_chk++; if (o_pc_l[0] !== 32'h8000_0000) begin n_fail++; $display("FAIL seq_o0_pc: got %h expected 80000000", o_pc_l[0]); end
    n_chk++; if (o_pc_l[1] !== 32'h8000_0004) begin n_fail++; $display("FAIL seq_o1_pc: got %h expected 80000004", o_pc_l[1]); end
    n_chk++; if (o_pc_l[2] !== 32'h8000_0008) begin n_fail++; $display("FAIL seq_o2_pc: got %h expected 80000008", o_pc_l[2]); end
    n_chk++; if (o_ir_l[1] !== 32'h7FFF_FFFB) begin n_fail++; $display("FAIL seq_o1_ir: got %h expected 7ffffffb", o_ir_l[1]); end
  endtask

  task automatic test_credit();
    do_reset();
    ifu_o_ready = 1'b0;
    repeat (10) cycle();
    n_chk++; if (rq_pc.size() != 4) begin n_fail++; $display("FAIL credit_req_count: got %0d expected 4", rq_pc.size()); end
    n_chk++; if (ifu_req_valid !== 1'b0) begin n_fail++; $display("FAIL credit_req_blocked: got %h expected 0", ifu_req_valid); end
    n_chk++; if (ifu_o_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL credit_head_pc: got %h expected 80000000", ifu_o_pc); end
    ifu_o_ready = 1'b1;
    cycle();
    ifu_o_ready = 1'b0;
    #1;
    n_chk++; if (ifu_req_valid !== 1'b1) begin n_fail++; $display("FAIL credit_req_resume: got %h expected 1", ifu_req_valid); end
    n_chk++; if (ifu_req_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL credit_resume_pc: got %h expected 80000010", ifu_req_pc); end
    n_chk++; if (ifu_o_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL credit_next_head: got %h expected 80000004", ifu_o_pc); end
  endtask

  task automatic test_flush();
    do_reset();
    rsp_en = 1'b0;
    repeat (3) cycle();
    n_chk++; if (ifu_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_outs_limit: got %h expected 0", ifu_req_valid); end
    pipe_flush_req = 1'b1; pipe_flush_pc = 32'h0000_0100;
    #1;
    n_chk++; if (pipe_flush_ack !== 1'b1 || ifu_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ack: got ack %h req %h expected ack 1 req 0", pipe_flush_ack, ifu_req_valid); end
    cycle();
    pipe_flush_req = 1'b0; rsp_en = 1'b1;
    rq_pc.delete(); rq_seq.delete();
    repeat (6) cycle();
    n_chk++; if (rq_pc.size() < 2 || o_pc_l.size() < 2) begin n_fail++; $display("FAIL flush_count: got req %0d out %0d expected >= 2", rq_pc.size(), o_pc_l.size()); end
    n_chk++; if (rq_pc[0] !== 32'h100 || rq_seq[0] !== 1'b0) begin n_fail++; $display("FAIL flush_first_req: got pc %h seq %h expected pc 100 seq 0", rq_pc[0], rq_seq[0]); end
    n_chk++; if (rq_pc[1] !== 32'h104 || rq_seq[1] !== 1'b1) begin n_fail++; $display("FAIL flush_second_req: got pc %h seq %h expected pc 104 seq 1", rq_pc[1], rq_seq[1]); end
    n_chk++; if (o_pc_l[0] !== 32'h100) begin n_fail++; $display("FAIL flush_o0_pc: got %h expected 100", o_pc_l[0]); end
    n_chk++; if (o_ir_l[0] !== 32'hFFFF_FEFF) begin n_fail++; $display("FAIL flush_o0_ir: got %h expected fffffeff", o_ir_l[0]); end
    n_chk++; if (o_pc_l[1] !== 32'h104) begin n_fail++; $display("FAIL flush_o1_pc: got %h expected 104", o_pc_l[1]); end
  endtask

  task automatic test_flush_rsp();
    do_reset();
    repeat (2) cycle();
    pipe_flush_req = 1'b1; pipe_flush_pc = 32'h0000_0200;
    cycle();
    pipe_flush_req = 1'b0;
    rq_pc.delete(); rq_seq.delete();
    repeat (5) cycle();
    n_chk++; if (rq_pc.size() < 1 || o_pc_l.size() < 2) begin n_fail++; $display("FAIL flrsp_count: got req %0d out %0d expected >=1 and >=2", rq_pc.size(), o_pc_l.size()); end
    n_chk++; if (rq_pc[0] !== 32'h200 || rq_seq[0] !== 1'b0) begin n_fail++; $display("FAIL flrsp_first_req: got pc %h seq %h expected pc 200 seq 0", rq_pc[0], rq_seq[0]); end
    n_chk++; if (o_pc_l[0] !== 32'h200) begin n_fail++; $display("FAIL flrsp_o0_pc: got %h expected 200", o_pc_l[0]); end
    n_chk++; if (o_pc_l[1] !== 32'h204) begin n_fail++; $display("FAIL flrsp_o1_pc: got %h expected 204", o_pc_l[1]); end
  endtask

  task automatic test_halt();
    do_reset();
    rsp_en = 1'b0;
    repeat (3) cycle();
    ifu_halt_req = 1'b1;
    cycle();
    n_chk++; if (ifu_halt_ack !== 1'b0 || ifu_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_pending0: got ack %h req %h expected 0 0", ifu_halt_ack, ifu_req_valid); end
    rsp_en = 1'b1;
    cycle();
    n_chk++; if (ifu_halt_ack !== 1'b0) begin n_fail++; $display("FAIL halt_pending1: got %h expected 0", ifu_halt_ack); end
    cycle();
    n_chk++; if (ifu_halt_ack !== 1'b1 || ifu_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt_ack_rise: got ack %h req %h expected 1 0", ifu_halt_ack, ifu_req_valid); end
    repeat (3) cycle();
    n_chk++; if (ifu_halt_ack !== 1'b1) begin n_fail++; $display("FAIL halt_ack_hold: got %h expected 1", ifu_halt_ack); end
    n_chk++; if (rq_pc.size() != 2) begin n_fail++; $display("FAIL halt_no_req: got %0d expected 2", rq_pc.size()); end
    n_chk++; if (o_pc_l.size() != 2) begin n_fail++; $display("FAIL halt_drain: got %0d expected 2", o_pc_l.size()); end
    ifu_halt_req = 1'b0;
    cycle();
    n_chk++; if (ifu_halt_ack !== 1'b0) begin n_fail++; $display("FAIL halt_ack_drop: got %h expected 0", ifu_halt_ack); end
    n_chk++; if (rq_pc.size() != 3 || rq_pc[2] !== 32'h8000_0008 || rq_seq[2] !== 1'b1) begin n_fail++; $display("FAIL halt_resume: got n %0d pc %h seq %h expected 3 80000008 1", rq_pc.size(), rq_pc[2], rq_seq[2]); end
  endtask

  task automatic test_buserr();
    do_reset();
    err_pc = 32'h8000_0004;
    repeat (8) cycle();
    n_chk++; if (o_pc_l.size() < 3) begin n_fail++; $display("FAIL err_count: got %0d expected >= 3", o_pc_l.size()); end
    n_chk++; if (o_err_l[0] !== 1'b0) begin n_fail++; $display("FAIL err_o0: got %h expected 0", o_err_l[0]); end
    n_chk++; if (o_err_l[1] !== 1'b1 || o_pc_l[1] !== 32'h8000_0004) begin n_fail++; $display("FAIL err_o1: got err %h pc %h expected 1 80000004", o_err_l[1], o_pc_l[1]); end
    n_chk++; if (o_err_l[2] !== 1'b0 || o_pc_l[2] !== 32'h8000_0008) begin n_fail++; $display("FAIL err_o2: got err %h pc %h expected 0 80000008", o_err_l[2], o_pc_l[2]); end
    n_chk++; if (rq_pc[3] !== 32'h8000_000C) begin n_fail++; $display("FAIL err_continue: got %h expected 8000000c", rq_pc[3]); end
  endtask

  initial begin
    ifu_req_ready = 1'b1; ifu_o_ready = 1'b1; rsp_en = 1'b1;
    pipe_flush_req = 1'b0; pipe_flush_pc = 32'h0; ifu_halt_req = 1'b0;
    ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_instr = 32'h0; err_pc = 32'hFFFF_FFFF;
    test_reset();
    test_sequential();
    test_credit();
    test_flush();
    test_flush_rsp();
    test_halt();
    test_buserr();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
